mem_dot_seq: RTL and testbench

- Sequencer that owns the dual-read / single-write scratch memory during one dot-product job.
- Walks two operand vectors stored in memory, one element pair per cycle over the two read ports, and accumulates signed Q-format products at full precision.
- Writes the rescaled, saturated result back through the write port and reports completion.
- Sits between the layer controller (start/done) and the memory instance; used for autoencoder neuron evaluation.

---
 rtl/mem_dot_seq.sv | 146 ++++++++++++++
 tb/tb_mem_dot_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dot_seq.sv
// Dot-product sequencer over a dual-read / single-write scratch memory.
// Define MEM_DOT_SEQ_RELU_EN to clamp negative results to zero on write-back.
module mem_dot_seq #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data
);

  localparam int ACC_W = 2*DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;

  state_t                   state_q;
  logic [ADDR_WIDTH-1:0]    a_base_q, b_base_q, dst_q;
  logic [ADDR_WIDTH-1:0]    rd1_q, rd2_q, waddr_q;
  logic [LEN_W-1:0]         len_q, idx_q, idx_d, len_eff;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   wdata_q;
  logic                     busy_q, done_q, wen_q, last;

  // Arithmetic shift floors toward minus infinity before clamping.
  function automatic logic signed [DATA_WIDTH-1:0] sat_f(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh, hi, lo;
    sh = v >>> FRAC_BITS;
    hi = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    lo = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    if (sh > hi)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (sh < lo) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else              return sh[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] result_f(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_WIDTH-1:0] s;
    s = sat_f(v);
`ifdef MEM_DOT_SEQ_RELU_EN
    if (s[DATA_WIDTH-1]) s = '0;
`endif
    return s;
  endfunction

  always_comb begin
    len_eff = (len > MAX_LEN) ? MAX_LEN : len;
    prod    = $signed(read_data_1) * $signed(read_data_2);
    acc_d   = acc_q + {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    idx_d   = idx_q + LEN_W'(1);
    last    = (idx_q == len_q - LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_base_q <= '0;
      b_base_q <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          wen_q  <= 1'b0;
          if (start) begin
            a_base_q <= a_base;
            b_base_q <= b_base;
            dst_q    <= dst_addr;
            len_q    <= len_eff;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            if (len_eff != '0) begin
              state_q <= S_RUN;
              rd1_q   <= a_base;
              rd2_q   <= b_base;
            end else begin
              // Empty job: go straight to write-back with a zero result.
              state_q <= S_WRITE;
              wen_q   <= 1'b1;
              waddr_q <= dst_addr;
              wdata_q <= '0;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          idx_q <= idx_d;
          if (last) begin
            state_q <= S_WRITE;
            wen_q   <= 1'b1;
            waddr_q <= dst_q;
            wdata_q <= result_f(acc_d);
          end else begin
            rd1_q <= a_base_q + idx_d[ADDR_WIDTH-1:0];
            rd2_q <= b_base_q + idx_d[ADDR_WIDTH-1:0];
          end
        end
        S_WRITE: begin
          state_q <= S_DONE;
          wen_q   <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign read_addr_1 = rd1_q;
  assign read_addr_2 = rd2_q;
  assign write_en    = wen_q;
  assign write_addr  = waddr_q;
  assign write_data  = wdata_q;

endmodule

// File: tb/tb_mem_dot_seq.sv
// Directed bench for mem_dot_seq with a behavioural scratch memory.
// Expectations follow MEM_DOT_SEQ_RELU_EN when the macro is defined.
module tb_mem_dot_seq;
  localparam int AW = 4;
  localparam int DW = 16;
`ifdef MEM_DOT_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] a_base, b_base, dst_addr;
  logic [AW:0]   len;
  logic          busy, done, write_en;
  logic [AW-1:0] read_addr_1, read_addr_2, write_addr;
  logic [DW-1:0] read_data_1, read_data_2, write_data;

  logic [DW-1:0] mem [0:15];
  logic [AW-1:0] ra1 [0:63];
  logic [AW-1:0] ra2 [0:63];
  int            n_cmp = 0, n_err = 0;
  int            wcount, done_cyc, busy_bad, cnt;
  logic [DW-1:0] wd;
  logic [AW-1:0] wa;

  always #5 clk = ~clk;

  assign read_data_1 = mem[read_addr_1];
  assign read_data_2 = mem[read_addr_2];

  mem_dot_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_base(a_base), .b_base(b_base), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data)
  );

  // Memory commits on the falling edge; the sample point is 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (write_en) mem[write_addr] = write_data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [AW:0] l, input int hold);
    a_base = a; b_base = b; dst_addr = d; len = l; start = 1'b1;
    wcount = 0; done_cyc = -1; busy_bad = 0;
    tick();
    for (int c = 1; c <= 60; c++) begin
      if (c > hold) start = 1'b0;
      else begin
        dst_addr = ~d;
        a_base   = a + 4'd1;
        len      = 5'd1;
      end
      ra1[c] = read_addr_1;
      ra2[c] = read_addr_2;
      if (!busy) busy_bad++;
      if (write_en) begin
        wcount++;
        wd = write_data;
        wa = write_addr;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0; start = 1'b0; a_base = '0; b_base = '0; dst_addr = '0; len = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", write_en, 0);
    chk("rst_ra12", {read_addr_1, read_addr_2}, 0);
    chk("rst_wa_wd", {write_addr, write_data}, 0);
    rst_n = 1'b1;
    tick();

    // Basic job: 1.0*1.0 + 2.0*1.0 + 0.5*2.0 = 4.0
    mem[0] = 16'h0100; mem[1] = 16'h0200; mem[2] = 16'h0080;
    mem[4] = 16'h0100; mem[5] = 16'h0100; mem[6] = 16'h0200;
    mem[8] = 16'hDEAD;
    run_job(4'd0, 4'd4, 4'd8, 5'd3, 0);
    chk("basic_mem8", mem[8], 16'h0400);
    chk("basic_done_cyc", done_cyc, 5);
    chk("basic_busy_gaps", busy_bad, 0);
    chk("basic_writes", wcount, 1);
    chk("basic_waddr", wa, 8);
    chk("basic_ra1_seq", {ra1[1], ra1[2], ra1[3]}, 12'h012);
    chk("basic_ra2_seq", {ra2[1], ra2[2], ra2[3]}, 12'h456);
    chk("basic_idle_busy", busy, 0);
    chk("basic_hold", {write_en, write_addr, write_data}, {1'b0, 4'd8, 16'h0400});

    // Positive and negative saturation
    mem[0] = 16'h7F00; mem[1] = 16'h7F00; mem[2] = 16'h7F00; mem[3] = 16'h7F00;
    run_job(4'd0, 4'd2, 4'd8, 5'd2, 0);
    chk("sat_pos", wd, 16'h7FFF);
    chk("sat_done_cyc", done_cyc, 4);
    mem[2] = 16'h8100; mem[3] = 16'h8100;
    run_job(4'd0, 4'd2, 4'd8, 5'd2, 0);
    chk("sat_neg", wd, RELU ? 16'h0000 : 16'h8000);

    // -1.0 * 3.0 = -3.0
    mem[0] = 16'hFF00; mem[1] = 16'h0300;
    run_job(4'd0, 4'd1, 4'd9, 5'd1, 0);
    chk("neg_mem9", mem[9], RELU ? 16'h0000 : 16'hFD00);
    // -1 LSB^2 scaled: floors to -1 LSB rather than 0
    mem[0] = 16'hFFFF; mem[1] = 16'h0001;
    run_job(4'd0, 4'd1, 4'd9, 5'd1, 0);
    chk("floor_tiny_neg", wd, RELU ? 16'h0000 : 16'hFFFF);

    // Zero length
    mem[3] = 16'h5555;
    run_job(4'd0, 4'd0, 4'd3, 5'd0, 0);
    chk("zero_mem3", mem[3], 16'h0000);
    chk("zero_done_cyc", done_cyc, 2);
    chk("zero_writes", wcount, 1);

    // Address wrap: A at E,F,0 = 1.0 each; B = 1,2,3 -> 6.0
    mem[14] = 16'h0100; mem[15] = 16'h0100; mem[0] = 16'h0100;
    mem[4] = 16'h0100; mem[5] = 16'h0200; mem[6] = 16'h0300;
    run_job(4'hE, 4'd4, 4'hA, 5'd3, 0);
    chk("wrap_ra1_seq", {ra1[1], ra1[2], ra1[3]}, 12'hEF0);
    chk("wrap_mem10", mem[10], 16'h0600);

    // len above 2^AW clamps to 16; identical ranges, destination inside them
    for (int i = 0; i < 16; i++) mem[i] = 16'h0100;
    run_job(4'd0, 4'd0, 4'd0, 5'd20, 0);
    chk("clamp_mem0", mem[0], 16'h1000);
    chk("clamp_done_cyc", done_cyc, 18);

    // Reset during RUN cycle 2 aborts with no write
    mem[9] = 16'h1234;
    a_base = 4'd0; b_base = 4'd0; dst_addr = 4'd9; len = 5'd8; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy_c1", busy, 1);
    tick();
    chk("abort_ra1_c2", read_addr_1, 1);
    rst_n = 1'b0;
    tick();
    chk("abort_ctrl_zero", {busy, done, write_en}, 0);
    chk("abort_addr_zero", {read_addr_1, read_addr_2, write_addr}, 0);
    chk("abort_wdata_zero", write_data, 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (write_en || busy) cnt++;
      tick();
    end
    chk("abort_quiet", cnt, 0);
    chk("abort_mem9", mem[9], 16'h1234);

    // start and parameter changes while busy are ignored
    mem[0] = 16'h0100; mem[1] = 16'h0100; mem[2] = 16'h0100;
    run_job(4'd0, 4'd0, 4'd11, 5'd3, 2);
    chk("busy_writes", wcount, 1);
    chk("busy_waddr", wa, 11);
    chk("busy_ra1_seq", {ra1[1], ra1[2], ra1[3]}, 12'h012);
    chk("busy_done_cyc", done_cyc, 5);
    chk("busy_mem11", mem[11], 16'h0300);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) cnt++;
      tick();
    end
    chk("busy_no_restart", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
